// File: rtl/tile_match_core.sv
// tile_match_core: pair-matching game core; tracks selections, matched tiles, move count,
// the best completed-game score and a timed reveal of mismatched pairs.
module tile_match_core #(
    parameter int NUM_TILES     = 10,
    parameter int SYM_W         = 3,
    parameter int SCORE_W       = 8,
    parameter int REVEAL_CYCLES = 25_000_000,
    parameter int IDX_W         = $clog2(NUM_TILES)
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       quit,
    input  logic                       sel_valid,
    input  logic [IDX_W-1:0]           sel_idx,
    input  logic [NUM_TILES*SYM_W-1:0] board,
    output logic                       in_game,
    output logic                       game_over,
    output logic [NUM_TILES-1:0]       shown,
    output logic [NUM_TILES-1:0]       matched,
    output logic [SYM_W-1:0]           sym_a,
    output logic [SYM_W-1:0]           sym_b,
    output logic [SCORE_W-1:0]         moves,
    output logic [SCORE_W-1:0]         best,
    output logic                       match_pulse,
    output logic                       miss_pulse,
    output logic                       illegal_pulse
);
    localparam int TW = REVEAL_CYCLES > 1 ? $clog2(REVEAL_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, DONE} state_t;
    state_t                     r_state, w_next;
    logic [NUM_TILES*SYM_W-1:0] r_board;
    logic [NUM_TILES-1:0]       r_matched, r_first_oh, r_second_oh, w_sel_oh;
    logic [SCORE_W-1:0]         r_moves, r_best;
    logic [TW-1:0]              r_timer;
    logic                       r_match_p, r_miss_p, r_ill_p;
    logic                       w_legal, w_eq, w_all;
    logic [SYM_W-1:0]           w_sym_a, w_sym_b;
    // Reveals are one-hot masks, so symbol lookup is an AND-OR over the latched board.
    always_comb begin
        w_sym_a = '0;
        w_sym_b = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            w_sym_a = w_sym_a | (r_first_oh[i]  ? r_board[i*SYM_W +: SYM_W] : '0);
            w_sym_b = w_sym_b | (r_second_oh[i] ? r_board[i*SYM_W +: SYM_W] : '0);
        end
    end
    assign w_sel_oh = NUM_TILES'(1) << sel_idx;
    assign w_legal  = (sel_idx < NUM_TILES) && ~|(w_sel_oh & (r_matched | r_first_oh));
    assign w_eq     = w_sym_a == w_sym_b;
    assign w_all    = &(r_matched | r_first_oh | r_second_oh);
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (quit) w_next = IDLE;
        else begin
            case (r_state)
                IDLE, DONE:  w_next = start ? WAIT_FIRST : r_state;
                WAIT_FIRST:  w_next = (sel_valid && w_legal) ? WAIT_SECOND : r_state;
                WAIT_SECOND: w_next = (sel_valid && w_legal) ? COMPARE : r_state;
                COMPARE:     w_next = !w_eq ? SHOW : (w_all ? DONE : WAIT_FIRST);
                SHOW:        w_next = (r_timer == '0) ? WAIT_FIRST : SHOW;
                default:     w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_board     <= '0;
            r_matched   <= '0;
            r_first_oh  <= '0;
            r_second_oh <= '0;
            r_moves     <= '0;
            r_best      <= '1;
            r_timer     <= '0;
            r_match_p   <= 1'b0;
            r_miss_p    <= 1'b0;
            r_ill_p     <= 1'b0;
        end else begin
            r_match_p <= 1'b0;
            r_miss_p  <= 1'b0;
            r_ill_p   <= 1'b0;
            if (quit) begin
                r_matched   <= '0;
                r_first_oh  <= '0;
                r_second_oh <= '0;
                r_moves     <= '0;
            end else begin
                case (r_state)
                    IDLE, DONE: if (start) begin
                        r_board   <= board;
                        r_matched <= '0;
                        r_moves   <= '0;
                    end
                    WAIT_FIRST: if (sel_valid) begin
                        if (w_legal) r_first_oh <= w_sel_oh;
                        else         r_ill_p    <= 1'b1;
                    end
                    WAIT_SECOND: if (sel_valid) begin
                        if (w_legal) begin
                            r_second_oh <= w_sel_oh;
                            r_moves     <= (r_moves == '1) ? r_moves : r_moves + SCORE_W'(1);
                        end else r_ill_p <= 1'b1;
                    end
                    COMPARE: begin
                        if (w_eq) begin
                            r_matched   <= r_matched | r_first_oh | r_second_oh;
                            r_first_oh  <= '0;
                            r_second_oh <= '0;
                            r_match_p   <= 1'b1;
                            if (w_all && r_moves < r_best) r_best <= r_moves;
                        end else begin
                            r_miss_p <= 1'b1;
                            r_timer  <= TW'(REVEAL_CYCLES - 1);
                        end
                    end
                    SHOW: begin
                        if (r_timer == '0) begin
                            r_first_oh  <= '0;
                            r_second_oh <= '0;
                        end else r_timer <= r_timer - TW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
    assign in_game       = r_state inside {WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW};
    assign game_over     = r_state == DONE;
    assign shown         = r_matched | r_first_oh | r_second_oh;
    assign matched       = r_matched;
    assign sym_a         = w_sym_a;
    assign sym_b         = w_sym_b;
    assign moves         = r_moves;
    assign best          = r_best;
    assign match_pulse   = r_match_p;
    assign miss_pulse    = r_miss_p;
    assign illegal_pulse = r_ill_p;
endmodule

// File: tb/tb_tile_match_core.sv
// tb_tile_match_core: directed game scenarios plus randomized play against a game-rule model;
// a second instance with a 2-bit score shares the stimulus to exercise move saturation.
module tb_tile_match_core;
    logic        clk = 0, resetn = 0, start = 0, quit = 0, sel_valid = 0;
    logic [2:0]  sel_idx = 0;
    logic [11:0] board = 0;
    logic        in_game, game_over, match_pulse, miss_pulse, illegal_pulse;
    logic [3:0]  shown, matched;
    logic [2:0]  sym_a, sym_b;
    logic [7:0]  moves, best;
    logic        b_in_game, b_game_over, b_match_pulse, b_miss_pulse, b_illegal_pulse;
    logic [3:0]  b_shown, b_matched;
    logic [2:0]  b_sym_a, b_sym_b;
    logic [1:0]  b_moves, b_best;
    int          checks = 0, errors = 0, m_best = 255;
    localparam logic [2:0] A = 3'd5, B = 3'd2;

    always #5 clk = ~clk;

    tile_match_core #(.NUM_TILES(4), .SYM_W(3), .SCORE_W(8), .REVEAL_CYCLES(3), .IDX_W(3)) u_dut (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .quit(quit), .sel_valid(sel_valid),
        .sel_idx(sel_idx), .board(board), .in_game(in_game), .game_over(game_over), .shown(shown),
        .matched(matched), .sym_a(sym_a), .sym_b(sym_b), .moves(moves), .best(best),
        .match_pulse(match_pulse), .miss_pulse(miss_pulse), .illegal_pulse(illegal_pulse));

    tile_match_core #(.NUM_TILES(4), .SYM_W(3), .SCORE_W(2), .REVEAL_CYCLES(3), .IDX_W(3)) u_sat (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .quit(quit), .sel_valid(sel_valid),
        .sel_idx(sel_idx), .board(board), .in_game(b_in_game), .game_over(b_game_over), .shown(b_shown),
        .matched(b_matched), .sym_a(b_sym_a), .sym_b(b_sym_b), .moves(b_moves), .best(b_best),
        .match_pulse(b_match_pulse), .miss_pulse(b_miss_pulse), .illegal_pulse(b_illegal_pulse));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input int idx);
        sel_valid = 1;
        sel_idx = 3'(idx);
        tick;
        sel_valid = 0;
    endtask

    task automatic test_reset;
        resetn = 0;
        tick;
        tick;
        resetn = 1;
        checks++; if (in_game !== 0) begin errors++; $display("FAIL reset_in_game: got %0h want 0", in_game); end
        checks++; if (game_over !== 0) begin errors++; $display("FAIL reset_game_over: got %0h want 0", game_over); end
        checks++; if (shown !== 0) begin errors++; $display("FAIL reset_shown: got %0h want 0", shown); end
        checks++; if (moves !== 0) begin errors++; $display("FAIL reset_moves: got %0h want 0", moves); end
        checks++; if (best !== 8'hFF) begin errors++; $display("FAIL reset_best: got %0h want ff", best); end
        checks++; if (b_best !== 2'b11) begin errors++; $display("FAIL reset_best_w2: got %0h want 3", b_best); end
        checks++; if ({match_pulse, miss_pulse, illegal_pulse, sym_a, sym_b} !== 0) begin
            errors++; $display("FAIL reset_misc: got %0h want 0", {match_pulse, miss_pulse, illegal_pulse, sym_a, sym_b}); end
    endtask

    task automatic test_match_game;
        board = {B, A, B, A};
        start = 1;
        tick;
        start = 0;
        checks++; if (in_game !== 1) begin errors++; $display("FAIL start_in_game: got %0h want 1", in_game); end
        pick(0);
        checks++; if (shown !== 4'b0001) begin errors++; $display("FAIL first_shown: got %0h want 1", shown); end
        checks++; if (sym_a !== A) begin errors++; $display("FAIL first_sym_a: got %0h want %0h", sym_a, A); end
        pick(2);
        checks++; if (moves !== 1) begin errors++; $display("FAIL second_moves: got %0h want 1", moves); end
        checks++; if (shown !== 4'b0101) begin errors++; $display("FAIL second_shown: got %0h want 5", shown); end
        checks++; if (sym_b !== A) begin errors++; $display("FAIL second_sym_b: got %0h want %0h", sym_b, A); end
        checks++; if (match_pulse !== 0) begin errors++; $display("FAIL early_match: got %0h want 0", match_pulse); end
        tick;
        checks++; if (match_pulse !== 1) begin errors++; $display("FAIL match_pulse: got %0h want 1", match_pulse); end
        checks++; if (matched !== 4'b0101) begin errors++; $display("FAIL matched: got %0h want 5", matched); end
        pick(1);
        checks++; if (match_pulse !== 0) begin errors++; $display("FAIL match_width: got %0h want 0", match_pulse); end
        pick(3);
        tick;
        checks++; if (game_over !== 1) begin errors++; $display("FAIL game_over: got %0h want 1", game_over); end
        checks++; if (moves !== 2) begin errors++; $display("FAIL done_moves: got %0h want 2", moves); end
        checks++; if (best !== 2) begin errors++; $display("FAIL done_best: got %0h want 2", best); end
        m_best = 2;
    endtask

    task automatic test_mismatch;
        start = 1;
        tick;
        start = 0;
        checks++; if (matched !== 0 || game_over !== 0) begin
            errors++; $display("FAIL restart: got matched %0h over %0h want 0 0", matched, game_over); end
        pick(0);
        pick(1);
        for (int k = 0; k < 4; k++) begin
            checks++; if (shown !== 4'b0011) begin errors++; $display("FAIL reveal_%0d: got %0h want 3", k, shown); end
            checks++; if (miss_pulse !== (k == 1)) begin errors++; $display("FAIL miss_%0d: got %0h want %0h", k, miss_pulse, k == 1); end
            if (k == 2) begin
                checks++; if (illegal_pulse !== 0 || moves !== 1) begin
                    errors++; $display("FAIL show_sel: got ill %0h moves %0h want 0 1", illegal_pulse, moves); end
            end
            sel_valid = (k == 1);
            sel_idx = 3'd2;
            tick;
            sel_valid = 0;
        end
        checks++; if (shown !== 0) begin errors++; $display("FAIL reveal_end: got %0h want 0", shown); end
        checks++; if (in_game !== 1 || moves !== 1) begin
            errors++; $display("FAIL after_show: got in %0h moves %0h want 1 1", in_game, moves); end
    endtask

    task automatic test_illegal;
        pick(0);
        pick(2);
        tick;
        pick(0);
        checks++; if (illegal_pulse !== 1 || shown !== 4'b0101) begin
            errors++; $display("FAIL ill_matched: got ill %0h shown %0h want 1 5", illegal_pulse, shown); end
        pick(1);
        checks++; if (illegal_pulse !== 0 || shown !== 4'b0111) begin
            errors++; $display("FAIL legal_first: got ill %0h shown %0h want 0 7", illegal_pulse, shown); end
        pick(1);
        checks++; if (illegal_pulse !== 1) begin errors++; $display("FAIL ill_same: got %0h want 1", illegal_pulse); end
        pick(5);
        checks++; if (illegal_pulse !== 1) begin errors++; $display("FAIL ill_range: got %0h want 1", illegal_pulse); end
        pick(2);
        checks++; if (illegal_pulse !== 1 || shown !== 4'b0111 || moves !== 2) begin
            errors++; $display("FAIL ill_second: got ill %0h shown %0h moves %0h want 1 7 2", illegal_pulse, shown, moves); end
        pick(3);
        tick;
        checks++; if (game_over !== 1 || moves !== 3 || best !== 2) begin
            errors++; $display("FAIL best_keep: got over %0h moves %0h best %0h want 1 3 2", game_over, moves, best); end
    endtask

    task automatic test_saturation;
        start = 1;
        tick;
        start = 0;
        for (int n = 1; n <= 6; n++) begin
            pick(0);
            pick(1);
            repeat (4) tick;
            checks++; if (moves !== 8'(n) || b_moves !== 2'(n > 3 ? 3 : n)) begin
                errors++; $display("FAIL sat_%0d: got %0h/%0h want %0h/%0h", n, moves, b_moves, n, n > 3 ? 3 : n); end
        end
    endtask

    task automatic test_quit;
        pick(0);
        quit = 1;
        tick;
        quit = 0;
        checks++; if (in_game !== 0 || shown !== 0 || moves !== 0 || matched !== 0) begin
            errors++; $display("FAIL quit: got in %0h shown %0h moves %0h want 0 0 0", in_game, shown, moves); end
        checks++; if (best !== 2) begin errors++; $display("FAIL quit_best: got %0h want 2", best); end
        start = 1;
        tick;
        start = 0;
        pick(0);
        quit = 1;
        sel_valid = 1;
        sel_idx = 3'd2;
        tick;
        quit = 0;
        sel_valid = 0;
        checks++; if (in_game !== 0 || shown !== 0 || illegal_pulse !== 0 || sym_b !== 0) begin
            errors++; $display("FAIL quit_sel: got in %0h shown %0h ill %0h want 0 0 0", in_game, shown, illegal_pulse); end
        tick;
        checks++; if (in_game !== 0) begin errors++; $display("FAIL quit_idle: got %0h want 0", in_game); end
    endtask

    task automatic test_random;
        logic [2:0] s[4];
        logic [2:0] t;
        logic [3:0] mm, oh;
        int j, first, mv, idx;
        bit done;
        resetn = 0;
        tick;
        resetn = 1;
        m_best = 255;
        for (int g = 0; g < 5; g++) begin
            s[0] = 3'($urandom); s[1] = s[0]; s[2] = 3'($urandom); s[3] = s[2];
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = s[i]; s[i] = s[j]; s[j] = t;
            end
            board = {s[3], s[2], s[1], s[0]};
            start = 1;
            tick;
            start = 0;
            mm = 0; first = -1; mv = 0; done = 0;
            for (int p = 0; p < 150 && !done; p++) begin
                idx = $urandom_range(0, 5);
                oh = 4'b0001 << idx;
                pick(idx);
                if (idx >= 4 || mm[idx] || idx == first) begin
                    checks++; if (illegal_pulse !== 1) begin errors++; $display("FAIL rnd_ill: got %0h want 1", illegal_pulse); end
                    checks++; if (shown !== (mm | (first < 0 ? 4'b0 : 4'b0001 << first))) begin
                        errors++; $display("FAIL rnd_ill_shown: got %0h", shown); end
                end else if (first < 0) begin
                    first = idx;
                    checks++; if (shown !== (mm | oh) || sym_a !== s[idx]) begin
                        errors++; $display("FAIL rnd_first: got %0h/%0h want %0h/%0h", shown, sym_a, mm | oh, s[idx]); end
                end else begin
                    mv++;
                    checks++; if (moves !== 8'(mv) || b_moves !== 2'(mv > 3 ? 3 : mv) || sym_b !== s[idx]) begin
                        errors++; $display("FAIL rnd_second: got %0h/%0h/%0h want %0h/%0h", moves, b_moves, sym_b, mv, s[idx]); end
                    tick;
                    if (s[first] == s[idx]) begin
                        mm[first] = 1;
                        mm[idx] = 1;
                        checks++; if (match_pulse !== 1 || matched !== mm) begin
                            errors++; $display("FAIL rnd_match: got %0h/%0h want 1/%0h", match_pulse, matched, mm); end
                        if (mm == 4'hF) begin
                            if (mv < m_best) m_best = mv;
                            done = 1;
                            checks++; if (game_over !== 1 || best !== 8'(m_best)) begin
                                errors++; $display("FAIL rnd_done: got %0h/%0h want 1/%0h", game_over, best, m_best); end
                        end
                    end else begin
                        checks++; if (miss_pulse !== 1) begin errors++; $display("FAIL rnd_miss: got %0h want 1", miss_pulse); end
                        repeat (4) tick;
                        checks++; if (shown !== mm || in_game !== 1) begin
                            errors++; $display("FAIL rnd_hide: got %0h want %0h", shown, mm); end
                    end
                    first = -1;
                end
            end
            if (!done) begin
                quit = 1;
                tick;
                quit = 0;
            end
        end
    endtask

    task automatic test_reset_mid_show;
        board = {B, A, B, A};
        start = 1;
        tick;
        start = 0;
        pick(0);
        pick(1);
        tick;
        tick;
        resetn = 0;
        tick;
        resetn = 1;
        checks++; if (in_game !== 0 || shown !== 0 || moves !== 0 || matched !== 0) begin
            errors++; $display("FAIL rst_show: got in %0h shown %0h moves %0h want 0 0 0", in_game, shown, moves); end
        checks++; if (best !== 8'hFF || miss_pulse !== 0) begin
            errors++; $display("FAIL rst_show_best: got %0h want ff", best); end
    endtask

    initial begin
        test_reset;
        test_match_game;
        test_mismatch;
        test_illegal;
        test_saturation;
        test_quit;
        test_random;
        test_reset_mid_show;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_match_core.md
# tile_match_core

Parametrised game core for the FPGA tile-matching game: holds a board of NUM_TILES face-down tiles, accepts player tile selections, compares pairs, counts moves and tracks the best (lowest) move count across games. It replaces the fixed two-FSM game/in-game pair under the board top level. LED, HEX or future VGA display logic consumes its `shown` mask and symbol outputs. New relative to the fixed design:
- configurable tile count and symbol width
- timed mismatch reveal
- illegal-selection flagging
- a persistent best-score register

## Interface
- NUM_TILES, default 10: tile count; even, 2..64.
- SYM_W, default 3: bits per tile symbol.
- SCORE_W, default 8: move counter and best-score width.
- REVEAL_CYCLES, default 25_000_000: mismatch display time in clocks; must be ≥1.
- IDX_W, default $clog2(NUM_TILES): selection index width.
- CLOCK_50  in  1: the one clock, all logic on its rising edge.
- resetn  in  1: synchronous reset, active-low. Clears everything, including best score.
- start  in  1: level; begins a game from IDLE or DONE.
- quit  in  1: level; abandons the game and returns to IDLE.
- sel_valid  in  1: one-cycle selection strobe.
- sel_idx  in  IDX_W: tile selected; sampled only when sel_valid is high.
- board  in  NUM_TILES*SYM_W: tile i symbol at bits [i*SYM_W +: SYM_W]; sampled on game start.
- in_game  out  1: high in WAIT_FIRST, WAIT_SECOND, COMPARE and SHOW.
- game_over  out  1: high in DONE.
- shown  out  NUM_TILES: matched tiles OR the currently revealed first/second tile.
- matched  out  NUM_TILES: tiles already paired.
- sym_a, sym_b  out  SYM_W each: symbols of the first and second revealed tiles; 0 when not revealed.
- moves  out  SCORE_W: pair attempts in the current game; saturates.
- best  out  SCORE_W: lowest `moves` of any completed game; all-ones when no game has completed.
- match_pulse, miss_pulse, illegal_pulse  out  1 each: one-cycle event flags.

## Operation
- States:
  - IDLE
  - WAIT_FIRST
  - WAIT_SECOND
  - COMPARE
  - SHOW
  - DONE
- Reset (resetn=0 at an edge) forces IDLE. All outputs are 0 except `best`, which is all-ones.
- IDLE/DONE, start=1: latch `board`, clear `matched`, clear `moves`, go to WAIT_FIRST. Leaving DONE by start keeps `matched` visible until that edge.
- WAIT_FIRST, legal sel: record the index as first and go to WAIT_SECOND. A selection is legal when sel_idx < NUM_TILES and the tile is not matched.
- WAIT_SECOND, legal sel: the tile must also differ from first. Record it as second, increment `moves` (saturating at 2^SCORE_W−1), go to COMPARE.
- Illegal sel (out of range, matched, or the same tile as first): `illegal_pulse` fires the next cycle. State and counters are unchanged.
- sel_valid in COMPARE, SHOW, IDLE or DONE is ignored, with no illegal_pulse.
- COMPARE, symbols equal:
  - set both matched bits and fire `match_pulse`
  - if all tiles are now matched, go to DONE; else go to WAIT_FIRST
  - on entry to DONE, if moves < best then best ← moves
- COMPARE, symbols differ: fire `miss_pulse`, load the reveal timer with REVEAL_CYCLES−1, go to SHOW.
- SHOW: decrement the timer. At 0, go to WAIT_FIRST and clear the first/second reveal.
- quit=1 in any non-IDLE state:
  - go to IDLE; clear `matched`, `shown` and `moves`
  - `best` is retained
  - quit has priority over start, sel_valid and timer expiry in the same cycle
- start while in_game is ignored.

## Timing
- Every output is registered; none is combinational from inputs.
- Selection latency: sel_valid at edge t updates `shown` and `sym_a`/`sym_b` at t+1.
- Second selection accepted at edge t:
  - `moves` updates at t+1 (state COMPARE)
  - outcome registered at t+2: `matched` updated or SHOW entered, plus the pulse
- Mismatch: the state is SHOW for exactly REVEAL_CYCLES cycles, so both tiles are visible for REVEAL_CYCLES+1 cycles counting COMPARE.
- Back-to-back selections on consecutive cycles are accepted, one per cycle.
- Event pulses are exactly one cycle wide.
- `best` update and `game_over` assert on the same edge.

## Test plan
- Reset mid-SHOW (NUM_TILES=4, REVEAL_CYCLES=3) -> next cycle: state IDLE, shown=0, moves=0, best=8'hFF.
- Board {0:A, 1:B, 2:A, 3:B}, start, select 0 then 2 -> match_pulse at t+2, matched=4'b0101, moves=1. Then select 1 then 3 -> game_over, moves=2, best=2.
- Select 0 then 1 (mismatch) -> miss_pulse; shown=4'b0011 for 4 cycles, then 0. Selection during SHOW is ignored and moves stays 1.
- Select 0, then 0 again; then select a matched tile; then sel_idx=5 -> illegal_pulse each time, state unchanged.
- SCORE_W=2, six mismatches -> moves saturates at 3.
- Second game finishing in 3 moves after best=2 -> best stays 2. Quit mid-game -> best retained, moves=0. Quit and sel_valid in the same cycle -> IDLE, the selection is dropped.
